// File: rtl/memory_pipe_if.sv
// Bus bundle for memory_pipe: an instruction fetch port and a latency-staged data port.
// Also carries the data-port FSM state so checkers can observe it.
interface memory_pipe_if #(
  parameter int DATA_W = 32
);
  logic [31:0]         address_inst;
  logic                inst_req;
  logic [DATA_W-1:0]   instruction;
  logic                inst_valid;

  logic [31:0]         address_data;
  logic [DATA_W-1:0]   data_receive;
  logic [DATA_W/8-1:0] byte_en;
  logic                mem_write;
  logic                mem_read;
  logic [DATA_W-1:0]   data_send;
  logic                data_ack;
  logic                busy;
  logic                addr_err;

  logic [1:0]          fsm_state;

  // Data handshake: a request (mem_read/mem_write plus operands) is taken on the
  // first rising edge where busy is low; the requester holds it until then.
  // Completion is a one-cycle data_ack, with addr_err qualifying it.
  // Fetch handshake: inst_req sampled at an edge yields inst_valid/instruction
  // on the following cycle, with no backpressure.
  modport master (
    output address_inst, inst_req, address_data, data_receive, byte_en,
           mem_write, mem_read,
    input  instruction, inst_valid, data_send, data_ack, busy, addr_err,
           fsm_state
  );

  modport slave (
    input  address_inst, inst_req, address_data, data_receive, byte_en,
           mem_write, mem_read,
    output instruction, inst_valid, data_send, data_ack, busy, addr_err,
           fsm_state
  );
endinterface

// File: rtl/memory_pipe.sv
// Word memory with a single-cycle instruction port and a LATENCY-staged data port.
// Optional build macro MEM_BYTE_WRITE_EN enables per-lane writes through byte_en.
module memory_pipe #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input logic          clk,
  input logic          start,
  memory_pipe_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int BW = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  state_t            state_d;
  logic [2:0]        cnt;
  logic [AW-1:0]     req_idx;
  logic [DATA_W-1:0] req_data;
  logic [BW-1:0]     req_be;
  logic              req_write;
  logic              req_err;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              mem_we;
  logic [AW-1:0]     data_idx;
  logic [AW-1:0]     inst_idx;

  // Addresses wrap modulo DEPTH words; low two bits select a byte and are dropped.
  assign data_idx = bus.address_data[AW+1:2];
  assign inst_idx = bus.address_inst[AW+1:2];

  assign accept        = (state == IDLE) && (bus.mem_read || bus.mem_write);
  assign mem_we        = (state == RESP) && req_write && !req_err;
  assign bus.busy      = (state != IDLE);
  assign bus.fsm_state = state;

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: if (accept) state_d = (LATENCY == 0) ? RESP : WAIT;
      WAIT: if (cnt <= 3'd1) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge start) begin
    if (start) begin
      state         <= IDLE;
      cnt           <= 3'd0;
      req_idx       <= '0;
      req_data      <= '0;
      req_be        <= '0;
      req_write     <= 1'b0;
      req_err       <= 1'b0;
      bus.data_send <= '0;
      bus.data_ack  <= 1'b0;
      bus.addr_err  <= 1'b0;
    end else begin
      state        <= state_d;
      bus.data_ack <= 1'b0;
      bus.addr_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            req_idx   <= data_idx;
            req_data  <= bus.data_receive;
            req_be    <= bus.byte_en;
            req_write <= bus.mem_write;
            req_err   <= (bus.address_data[1:0] != 2'b00) ||
                         (bus.mem_read && bus.mem_write);
            cnt       <= 3'(LATENCY);
          end
        end
        WAIT: begin
          if (cnt != 3'd0) cnt <= cnt - 3'd1;
        end
        RESP: begin
          bus.data_ack <= 1'b1;
          bus.addr_err <= req_err;
          // Writes and faulted requests leave the last good read word in place.
          if (!req_err && !req_write) bus.data_send <= mem[req_idx];
        end
        default: ;
      endcase
    end
  end

  // The array is deliberately outside the reset domain.
`ifdef MEM_BYTE_WRITE_EN
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < BW; i++) begin
        if (req_be[i]) mem[req_idx][i*8 +: 8] <= req_data[i*8 +: 8];
      end
    end
  end

  logic unused_addr;
  assign unused_addr = ^{bus.address_data[31:AW+2], bus.address_inst[31:AW+2],
                         bus.address_inst[1:0]};
`else
  always_ff @(posedge clk) begin
    if (mem_we) mem[req_idx] <= req_data;
  end

  logic unused_addr;
  assign unused_addr = ^{bus.address_data[31:AW+2], bus.address_inst[31:AW+2],
                         bus.address_inst[1:0], req_be};
`endif

  // Non-blocking read of the array gives read-before-write against a same-edge data write.
  always_ff @(posedge clk or posedge start) begin
    if (start) begin
      bus.instruction <= '0;
      bus.inst_valid  <= 1'b0;
    end else begin
      bus.inst_valid <= bus.inst_req;
      if (bus.inst_req) bus.instruction <= mem[inst_idx];
    end
  end
endmodule

// File: tb/tb_memory_pipe.sv
// Directed bench for memory_pipe (DATA_W=32, DEPTH=256, LATENCY=2).
module tb_memory_pipe;
  logic clk = 1'b0;
  logic start;
  int   checks   = 0;
  int   failures = 0;
  int   lat;
  logic [31:0] byte_exp;
  logic        seen_ack;

  always #5 clk = ~clk;

  memory_pipe_if #(.DATA_W(32)) bus ();

  memory_pipe #(
    .DATA_W (32),
    .DEPTH  (256),
    .LATENCY(2)
  ) dut (
    .clk  (clk),
    .start(start),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one data request and return cycles from the accepting edge to data_ack.
  task automatic data_op(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] be, output int cycles);
    int guard;
    guard = 0;
    while (bus.busy && guard < 32) begin
      tick();
      guard++;
    end
    bus.mem_read     = rd;
    bus.mem_write    = wr;
    bus.address_data = addr;
    bus.data_receive = wd;
    bus.byte_en      = be;
    tick();
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    cycles = 0;
    while (!bus.data_ack && cycles < 16) begin
      tick();
      cycles++;
    end
  endtask

  task automatic fetch(input logic [31:0] addr);
    bus.address_inst = addr;
    bus.inst_req     = 1'b1;
    tick();
    bus.inst_req = 1'b0;
  endtask

  initial begin
    start            = 1'b1;
    bus.address_inst = '0;
    bus.inst_req     = 1'b0;
    bus.address_data = '0;
    bus.data_receive = '0;
    bus.byte_en      = '0;
    bus.mem_write    = 1'b0;
    bus.mem_read     = 1'b0;
    tick();
    tick();

    chk("rst_instruction", bus.instruction, 32'h0);
    chk("rst_inst_valid",  32'(bus.inst_valid), 32'h0);
    chk("rst_data_send",   bus.data_send, 32'h0);
    chk("rst_data_ack",    32'(bus.data_ack), 32'h0);
    chk("rst_busy",        32'(bus.busy), 32'h0);
    chk("rst_addr_err",    32'(bus.addr_err), 32'h0);
    chk("rst_state",       32'(bus.fsm_state), 32'h0);
    start = 1'b0;
    tick();

    // Basic write then read of word 0
    data_op(1'b0, 1'b1, 32'h0, 32'hAAAA_AAAA, 4'hF, lat);
    chk("wr0_latency", 32'(lat), 32'd3);
    chk("wr0_err",     32'(bus.addr_err), 32'h0);
    data_op(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, lat);
    chk("rd0_latency", 32'(lat), 32'd3);
    chk("rd0_data",    bus.data_send, 32'hAAAA_AAAA);
    chk("rd0_err",     32'(bus.addr_err), 32'h0);
    tick();
    chk("rd0_ack_one_cycle", 32'(bus.data_ack), 32'h0);

    // Partial-lane write, issued back-to-back
    data_op(1'b0, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'hF, lat);
    chk("wr10_latency", 32'(lat), 32'd3);
    chk("wr_keeps_data_send", bus.data_send, 32'hAAAA_AAAA);
    data_op(1'b0, 1'b1, 32'h10, 32'h1234_5678, 4'b0011, lat);
    chk("wr10b_b2b_latency", 32'(lat), 32'd3);
    data_op(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, lat);
`ifdef MEM_BYTE_WRITE_EN
    byte_exp = 32'hFFFF_5678;
`else
    byte_exp = 32'h1234_5678;
`endif
    chk("rd10_data", bus.data_send, byte_exp);

    // Faulted requests: misaligned read, then read+write together
    data_op(1'b1, 1'b0, 32'h6, 32'h0, 4'h0, lat);
    chk("misalign_latency", 32'(lat), 32'd3);
    chk("misalign_err",     32'(bus.addr_err), 32'h1);
    chk("misalign_keep",    bus.data_send, byte_exp);
    data_op(1'b1, 1'b1, 32'h10, 32'h0BAD_0BAD, 4'hF, lat);
    chk("rdwr_err", 32'(bus.addr_err), 32'h1);
    data_op(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, lat);
    chk("rdwr_no_write", bus.data_send, byte_exp);
    chk("err_cleared",   32'(bus.addr_err), 32'h0);

    // Address wrap, seen from both ports
    data_op(1'b0, 1'b1, 32'h400, 32'hABCD_ABCD, 4'hF, lat);
    fetch(32'h0);
    chk("fetch0_valid", 32'(bus.inst_valid), 32'h1);
    chk("fetch0_data",  bus.instruction, 32'hABCD_ABCD);
    tick();
    chk("fetch_valid_drop", 32'(bus.inst_valid), 32'h0);
    fetch(32'h403);
    chk("fetch_lowbits_ignored", bus.instruction, 32'hABCD_ABCD);
    data_op(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, lat);
    chk("rd_wrapped", bus.data_send, 32'hABCD_ABCD);

    // Reset while a write sits in WAIT
    data_op(1'b0, 1'b1, 32'h8, 32'h5A5A_5A5A, 4'hF, lat);
    bus.address_data = 32'h8;
    bus.data_receive = 32'h1111_1111;
    bus.byte_en      = 4'hF;
    bus.mem_write    = 1'b1;
    tick();
    bus.mem_write = 1'b0;
    tick();
    chk("midop_busy", 32'(bus.busy), 32'h1);
    start = 1'b1;
    #1;
    chk("midop_rst_state",     32'(bus.fsm_state), 32'h0);
    chk("midop_rst_busy",      32'(bus.busy), 32'h0);
    chk("midop_rst_data_send", bus.data_send, 32'h0);
    chk("midop_rst_instr",     bus.instruction, 32'h0);
    chk("midop_rst_ack",       32'(bus.data_ack), 32'h0);
    tick();
    start    = 1'b0;
    seen_ack = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen_ack = seen_ack | bus.data_ack;
    end
    chk("midop_no_ack", 32'(seen_ack), 32'h0);
    data_op(1'b1, 1'b0, 32'h8, 32'h0, 4'h0, lat);
    chk("midop_old_word", bus.data_send, 32'h5A5A_5A5A);

    // Fetch and data write to the same word on the same edge
    data_op(1'b0, 1'b1, 32'h4, 32'h0BAD_0004, 4'hF, lat);
    bus.address_data = 32'h4;
    bus.data_receive = 32'h2222_2222;
    bus.byte_en      = 4'hF;
    bus.mem_write    = 1'b1;
    tick();
    bus.mem_write = 1'b0;
    tick();
    tick();
    chk("rbw_in_resp", 32'(bus.fsm_state), 32'h2);
    bus.address_inst = 32'h4;
    bus.inst_req     = 1'b1;
    tick();
    chk("rbw_ack",       32'(bus.data_ack), 32'h1);
    chk("rbw_old_word",  bus.instruction, 32'h0BAD_0004);
    tick();
    chk("rbw_new_word",  bus.instruction, 32'h2222_2222);
    bus.inst_req = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
